// File: rtl/ram_dma.sv
// Block-transfer initiator for a 4K x 16 dual-port RAM: forward copy (memmove
// order, relying on the RAM's write-first read) and constant fill, one word per clock.
module ram_dma #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Mode,
  input  logic [AW-1:0] SrcAddr,
  input  logic [AW-1:0] DstAddr,
  input  logic [AW:0]   Len,
  input  logic [DW-1:0] FillData,
  output logic          Busy,
  output logic          Done,
  output logic          RamWe,
  output logic [AW-1:0] RamWaddr,
  output logic [AW-1:0] RamRaddr,
  output logic [DW-1:0] RamDin,
  input  logic [DW-1:0] RamDout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COPY,
    S_FLUSH,
    S_FILL
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          w_done_next;
  logic          w_we;
  logic          w_accept;
  logic          w_accept_zero;
  logic [AW:0]   w_rd_cnt_inc;
  logic [AW:0]   w_wr_cnt_inc;

  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic [AW:0]   r_len;
  logic [DW-1:0] r_fill;
  logic [AW:0]   r_rd_cnt;
  logic [AW:0]   r_wr_cnt;
  logic          r_rd_valid;
  logic [AW-1:0] r_raddr;
  logic          r_done;

  assign w_accept      = (r_state == S_IDLE) && Start && (Len != '0);
  assign w_accept_zero = (r_state == S_IDLE) && Start && (Len == '0);
  assign w_rd_cnt_inc  = r_rd_cnt + (AW+1)'(1);
  assign w_wr_cnt_inc  = r_wr_cnt + (AW+1)'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    w_we         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept)      w_state_next = Mode ? S_FILL : S_COPY;
        if (w_accept_zero) w_done_next  = 1'b1;
      end
      S_COPY: begin
        w_we = r_rd_valid;
        if (w_rd_cnt_inc == r_len) w_state_next = S_FLUSH;
      end
      S_FLUSH: begin
        w_we         = 1'b1;
        w_state_next = S_IDLE;
        w_done_next  = 1'b1;
      end
      S_FILL: begin
        w_we = 1'b1;
        if (w_wr_cnt_inc == r_len) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_src      <= '0;
      r_dst      <= '0;
      r_len      <= '0;
      r_fill     <= '0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_rd_valid <= 1'b0;
      r_raddr    <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_done_next;
      if (w_accept) begin
        r_src      <= SrcAddr;
        r_dst      <= DstAddr;
        r_len      <= Len;
        r_fill     <= FillData;
        r_rd_cnt   <= '0;
        r_wr_cnt   <= '0;
        r_rd_valid <= 1'b0;
        if (!Mode) r_raddr <= SrcAddr;
      end else begin
        unique case (r_state)
          S_COPY: begin
            // Read address is kept as src + rd_cnt so it can hold in FILL/IDLE.
            r_rd_cnt   <= w_rd_cnt_inc;
            r_raddr    <= r_src + w_rd_cnt_inc[AW-1:0];
            r_rd_valid <= 1'b1;
            if (r_rd_valid) r_wr_cnt <= w_wr_cnt_inc;
          end
          S_FLUSH: begin
            r_wr_cnt   <= w_wr_cnt_inc;
            r_rd_valid <= 1'b0;
          end
          S_FILL:  r_wr_cnt <= w_wr_cnt_inc;
          default: ;
        endcase
      end
    end
  end

  // Copy data passes straight from the RAM read port to the write port.
  assign Busy     = (r_state != S_IDLE);
  assign Done     = r_done;
  assign RamWe    = w_we;
  assign RamWaddr = r_dst + r_wr_cnt[AW-1:0];
  assign RamRaddr = r_raddr;
  assign RamDin   = (r_state == S_FILL) ? r_fill : RamDout;

endmodule

// File: tb/tb_ram_dma.sv
// Directed bench for ram_dma with a write-first 4K x 16 RAM model and
// activity counters (busy cycles, writes, per-address hits, Done pulses).
module tb_ram_dma;

  logic        Clk, Reset, Start, Mode;
  logic [11:0] SrcAddr, DstAddr;
  logic [12:0] Len;
  logic [15:0] FillData;
  logic        Busy, Done, RamWe;
  logic [11:0] RamWaddr, RamRaddr;
  logic [15:0] RamDin, RamDout;

  logic [15:0] mem [4096];
  logic [15:0] dout_q;
  logic        pl_we;
  logic [11:0] pl_addr;
  logic [15:0] pl_data;
  logic        clr_req;

  int busy_cnt, done_cnt, we_cnt, both_cnt, first_we;
  int hits [4096];
  int n_tests = 0;
  int n_fail  = 0;

  ram_dma #(.AW(12), .DW(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Len(Len), .FillData(FillData),
    .Busy(Busy), .Done(Done), .RamWe(RamWe), .RamWaddr(RamWaddr),
    .RamRaddr(RamRaddr), .RamDin(RamDin), .RamDout(RamDout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Write-first RAM: the read registered at an edge sees that edge's write.
  assign RamDout = dout_q;
  always @(posedge Clk) begin
    if (pl_we)      mem[pl_addr]  = pl_data;
    else if (RamWe) mem[RamWaddr] = RamDin;
    dout_q <= mem[RamRaddr];
  end

  always @(posedge Clk) begin
    if (clr_req) begin
      busy_cnt = 0; done_cnt = 0; we_cnt = 0; both_cnt = 0; first_we = 0;
      for (int a = 0; a < 4096; a++) hits[a] = 0;
    end else begin
      if (Busy) busy_cnt++;
      if (Done) done_cnt++;
      if (Busy && Done) both_cnt++;
      if (RamWe) begin
        we_cnt++;
        hits[RamWaddr]++;
        if (first_we == 0) first_we = busy_cnt;
      end
    end
  end

  task automatic preload(input logic [11:0] addr, input logic [15:0] data);
    @(negedge Clk);
    pl_we = 1'b1; pl_addr = addr; pl_data = data;
    @(negedge Clk);
    pl_we = 1'b0;
  endtask

  task automatic clear_stats();
    @(negedge Clk); clr_req = 1'b1;
    @(negedge Clk); clr_req = 1'b0;
  endtask

  // Issues one command; lat = cycles from the accepting edge to Done.
  // inj!=0 pulses a conflicting fill command on that busy cycle.
  task automatic run_cmd(input logic mode, input logic [11:0] src, input logic [11:0] dst,
                         input logic [12:0] len, input logic [15:0] fill, input int inj,
                         output int lat);
    logic got;
    got = 1'b0;
    @(negedge Clk);
    Start = 1'b1; Mode = mode; SrcAddr = src; DstAddr = dst; Len = len; FillData = fill;
    lat = 0;
    for (int k = 1; k <= 5000; k++) begin
      @(negedge Clk);
      lat = k;
      Start = (inj != 0 && k == inj);
      if (Start) begin
        Mode = 1'b1; DstAddr = dst; Len = 13'd2; FillData = 16'hFFFF;
      end
      if (Done) begin got = 1'b1; break; end
    end
    Start = 1'b0;
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL done_timeout: no Done within %0d cycles", lat); end
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    n_tests++; if (Busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_tests++; if (Done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b want 0", Done); end
    n_tests++; if (RamWe !== 1'b0)     begin n_fail++; $display("FAIL reset_we: got %b want 0", RamWe); end
    n_tests++; if (RamWaddr !== 12'h0) begin n_fail++; $display("FAIL reset_waddr: got %h want 000", RamWaddr); end
    n_tests++; if (RamRaddr !== 12'h0) begin n_fail++; $display("FAIL reset_raddr: got %h want 000", RamRaddr); end
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_fill();
    int lat;
    preload(12'h104, 16'h0000);
    clear_stats();
    run_cmd(1'b1, 12'h000, 12'h100, 13'd4, 16'hA5A5, 0, lat);
    n_tests++; if (lat !== 5)      begin n_fail++; $display("FAIL fill_latency: got %0d want 5", lat); end
    n_tests++; if (busy_cnt !== 4) begin n_fail++; $display("FAIL fill_busy: got %0d want 4", busy_cnt); end
    n_tests++; if (we_cnt !== 4)   begin n_fail++; $display("FAIL fill_writes: got %0d want 4", we_cnt); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL fill_done: got %0d want 1", done_cnt); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (mem[12'h100 + i] !== 16'hA5A5 || hits[12'h100 + i] !== 1) begin
        n_fail++;
        $display("FAIL fill_word[%0d]: got %h hits %0d want a5a5 hits 1", i, mem[12'h100 + i], hits[12'h100 + i]);
      end
    end
    n_tests++; if (mem[12'h104] !== 16'h0000) begin n_fail++; $display("FAIL fill_past_end: got %h want 0000", mem[12'h104]); end
  endtask

  task automatic test_copy();
    int lat;
    for (int i = 0; i < 8; i++) preload(12'(i), 16'h1000 + 16'(i));
    clear_stats();
    run_cmd(1'b0, 12'h000, 12'h800, 13'd8, 16'h0, 0, lat);
    n_tests++; if (lat !== 10)     begin n_fail++; $display("FAIL copy_latency: got %0d want 10", lat); end
    n_tests++; if (busy_cnt !== 9) begin n_fail++; $display("FAIL copy_busy: got %0d want 9", busy_cnt); end
    n_tests++; if (first_we !== 2) begin n_fail++; $display("FAIL copy_first_write: got cycle %0d want 2", first_we); end
    n_tests++; if (we_cnt !== 8)   begin n_fail++; $display("FAIL copy_writes: got %0d want 8", we_cnt); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL copy_done: got %0d want 1", done_cnt); end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (mem[12'h800 + i] !== 16'h1000 + 16'(i)) begin
        n_fail++; $display("FAIL copy_word[%0d]: got %h want %h", i, mem[12'h800 + i], 16'h1000 + 16'(i));
      end
    end
  endtask

  task automatic test_overlap_wrap();
    int lat;
    preload(12'hFFE, 16'h1111); preload(12'hFFF, 16'h2222);
    preload(12'h000, 16'hDEAD); preload(12'h001, 16'hDEAD); preload(12'h002, 16'hBEEF);
    clear_stats();
    run_cmd(1'b0, 12'hFFE, 12'hFFF, 13'd3, 16'h0, 0, lat);
    n_tests++; if (mem[12'hFFF] !== 16'h1111) begin n_fail++; $display("FAIL wrap_fff: got %h want 1111", mem[12'hFFF]); end
    n_tests++; if (mem[12'h000] !== 16'h1111) begin n_fail++; $display("FAIL wrap_000: got %h want 1111", mem[12'h000]); end
    n_tests++; if (mem[12'h001] !== 16'h1111) begin n_fail++; $display("FAIL wrap_001: got %h want 1111", mem[12'h001]); end
    n_tests++; if (mem[12'h002] !== 16'hBEEF) begin n_fail++; $display("FAIL wrap_002: got %h want beef", mem[12'h002]); end
    n_tests++; if (mem[12'hFFE] !== 16'h1111) begin n_fail++; $display("FAIL wrap_src: got %h want 1111", mem[12'hFFE]); end
    // Dst below Src: plain memmove down by two words.
    for (int i = 0; i < 6; i++) preload(12'h200 + 12'(i), 16'hC000 + 16'(i));
    run_cmd(1'b0, 12'h202, 12'h200, 13'd4, 16'h0, 0, lat);
    for (int i = 0; i < 6; i++) begin
      logic [15:0] exp;
      exp = (i < 4) ? 16'hC002 + 16'(i) : 16'hC000 + 16'(i);
      n_tests++;
      if (mem[12'h200 + i] !== exp) begin
        n_fail++; $display("FAIL memmove_down[%0d]: got %h want %h", i, mem[12'h200 + i], exp);
      end
    end
  endtask

  task automatic test_len0();
    int lat;
    clear_stats();
    run_cmd(1'b0, 12'h010, 12'h020, 13'd0, 16'h0, 0, lat);
    n_tests++; if (lat !== 1)      begin n_fail++; $display("FAIL len0_latency: got %0d want 1", lat); end
    n_tests++; if (we_cnt !== 0)   begin n_fail++; $display("FAIL len0_writes: got %0d want 0", we_cnt); end
    n_tests++; if (busy_cnt !== 0) begin n_fail++; $display("FAIL len0_busy: got %0d want 0", busy_cnt); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL len0_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_len_max();
    int lat, bad_hits, bad_data;
    clear_stats();
    run_cmd(1'b1, 12'h000, 12'h000, 13'h1000, 16'h5A5A, 0, lat);
    bad_hits = 0; bad_data = 0;
    for (int a = 0; a < 4096; a++) begin
      if (hits[a] != 1) bad_hits++;
      if (mem[a] !== 16'h5A5A) bad_data++;
    end
    n_tests++; if (busy_cnt !== 4096) begin n_fail++; $display("FAIL max_busy: got %0d want 4096", busy_cnt); end
    n_tests++; if (we_cnt !== 4096)   begin n_fail++; $display("FAIL max_writes: got %0d want 4096", we_cnt); end
    n_tests++; if (bad_hits !== 0)    begin n_fail++; $display("FAIL max_once_each: got %0d bad addrs want 0", bad_hits); end
    n_tests++; if (bad_data !== 0)    begin n_fail++; $display("FAIL max_data: got %0d bad words want 0", bad_data); end
    n_tests++; if (done_cnt !== 1)    begin n_fail++; $display("FAIL max_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int i = 0; i < 4; i++) preload(12'h300 + 12'(i), 16'h3000 + 16'(i));
    clear_stats();
    run_cmd(1'b0, 12'h300, 12'h400, 13'd4, 16'h0, 2, lat);
    repeat (3) @(negedge Clk);
    n_tests++; if (lat !== 6)      begin n_fail++; $display("FAIL b2b_latency: got %0d want 6", lat); end
    n_tests++; if (busy_cnt !== 5) begin n_fail++; $display("FAIL b2b_busy: got %0d want 5", busy_cnt); end
    n_tests++; if (we_cnt !== 4)   begin n_fail++; $display("FAIL b2b_writes: got %0d want 4", we_cnt); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL b2b_done: got %0d want 1", done_cnt); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (mem[12'h400 + i] !== 16'h3000 + 16'(i)) begin
        n_fail++; $display("FAIL b2b_word[%0d]: got %h want %h", i, mem[12'h400 + i], 16'h3000 + 16'(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      preload(12'h500 + 12'(i), 16'h5000 + 16'(i));
      preload(12'h600 + 12'(i), 16'h0000);
    end
    clear_stats();
    @(negedge Clk);
    Start = 1'b1; Mode = 1'b0; SrcAddr = 12'h500; DstAddr = 12'h600; Len = 13'd8;
    @(negedge Clk); Start = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;                 // during the third write cycle
    @(negedge Clk);
    n_tests++; if (RamWe !== 1'b0) begin n_fail++; $display("FAIL abort_we: got %b want 0", RamWe); end
    n_tests++; if (Busy !== 1'b0)  begin n_fail++; $display("FAIL abort_busy: got %b want 0", Busy); end
    n_tests++; if (Done !== 1'b0)  begin n_fail++; $display("FAIL abort_done_now: got %b want 0", Done); end
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    n_tests++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_done: got %0d want 0", done_cnt); end
    n_tests++; if (we_cnt !== 3)   begin n_fail++; $display("FAIL abort_writes: got %0d want 3", we_cnt); end
    for (int i = 0; i < 4; i++) begin
      logic [15:0] exp;
      exp = (i < 3) ? 16'h5000 + 16'(i) : 16'h0000;
      n_tests++;
      if (mem[12'h600 + i] !== exp) begin
        n_fail++; $display("FAIL abort_word[%0d]: got %h want %h", i, mem[12'h600 + i], exp);
      end
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Mode = 1'b0; SrcAddr = '0; DstAddr = '0;
    Len = '0; FillData = '0; pl_we = 1'b0; pl_addr = '0; pl_data = '0; clr_req = 1'b0;
    test_reset();
    test_fill();
    test_copy();
    test_overlap_wrap();
    test_len0();
    test_back_to_back();
    test_reset_mid();
    test_len_max();
    n_tests++; if (both_cnt !== 0) begin n_fail++; $display("FAIL busy_and_done: got %0d cycles want 0", both_cnt); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
